// File: rtl/xbar_vlat_pkg.sv
// xbar_vlat_pkg: index and counter width helpers shared by the variable-latency crossbar files
package xbar_vlat_pkg;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/xbar_vlat_idx_fifo.sv
// xbar_vlat_idx_fifo: master-index FIFO; push_i/data_i in, pop_i out, full_o/empty_o/head_o status, async active-low rst_ni
module xbar_vlat_idx_fifo
  import xbar_vlat_pkg::*;
#(
  parameter int Depth = 4,
  parameter int Width = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] data_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [Width-1:0] head_o
);
  localparam int PW = idx_w(Depth);
  localparam int CW = cnt_w(Depth);
  logic [Depth-1:0][Width-1:0] mem;
  logic [PW-1:0] rd, wr;
  logic [CW-1:0] cnt;
  logic do_push, do_pop;
  assign full_o = cnt == CW'(Depth);
  assign empty_o = cnt == '0;
  assign head_o = mem[rd];
  assign do_push = push_i && !full_o;
  assign do_pop = pop_i && !empty_o;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem <= '0;
      rd <= '0;
      wr <= '0;
      cnt <= '0;
    end else begin
      if (do_push) begin
        mem[wr] <= data_i;
        wr <= wr == PW'(Depth - 1) ? '0 : wr + PW'(1);
      end
      if (do_pop) rd <= rd == PW'(Depth - 1) ? '0 : rd + PW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(push_i && full_o));
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(pop_i && empty_o));
endmodule

// File: rtl/xbar_vlat.sv
// xbar_vlat: NumIn x NumOut crossbar, masters (req/add/wen/wdata -> gnt, vld/rdata) to targets (req/wen/wdata <- gnt, rvld/rdata) with target-driven latency
module xbar_vlat
  import xbar_vlat_pkg::*;
#(
  parameter int NumIn = 4,
  parameter int NumOut = 4,
  parameter int ReqDataWidth = 32,
  parameter int RespDataWidth = 32,
  parameter int MaxOutstanding = 4,
  parameter int MaxOutPerMaster = 4,
  parameter bit WriteRespOn = 1'b1,
  parameter bit ExtPrio = 1'b0
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic [NumOut-1:0][idx_w(NumIn)-1:0]     rr_i,
  input  logic [NumIn-1:0]                        req_i,
  input  logic [NumIn-1:0][idx_w(NumOut)-1:0]     add_i,
  input  logic [NumIn-1:0]                        wen_i,
  input  logic [NumIn-1:0][ReqDataWidth-1:0]      wdata_i,
  output logic [NumIn-1:0]                        gnt_o,
  output logic [NumIn-1:0]                        vld_o,
  output logic [NumIn-1:0][RespDataWidth-1:0]     rdata_o,
  output logic [NumOut-1:0]                       req_o,
  input  logic [NumOut-1:0]                       gnt_i,
  output logic [NumOut-1:0]                       wen_o,
  output logic [NumOut-1:0][ReqDataWidth-1:0]     wdata_o,
  input  logic [NumOut-1:0]                       rvld_i,
  input  logic [NumOut-1:0][RespDataWidth-1:0]    rdata_i
);
  localparam int IW = idx_w(NumIn);
  localparam int OW = idx_w(NumOut);
  localparam int CW = cnt_w(MaxOutPerMaster);
  typedef logic [IW-1:0] idx_t;
  logic [NumIn-1:0][CW-1:0] cnt;
  logic [NumIn-1:0][OW-1:0] last;
  idx_t [NumOut-1:0] ptr, win, head;
  logic [NumOut-1:0][NumIn-1:0] elig;
  logic [NumIn-1:0][NumOut-1:0] hit;
  logic [NumOut-1:0] full, empty, hs, push;
  logic [NumIn-1:0] inc;
  function automatic idx_t rr_pick(input logic [NumIn-1:0] e, input idx_t p);
    idx_t w = '0;
    for (int o = NumIn - 1; o >= 0; o--)
      if (e[(int'(p) + o) % NumIn]) w = IW'((int'(p) + o) % NumIn);
    return w;
  endfunction
  // A master may only stay on its current target until it drains, so responses return in order.
  always_comb begin
    elig = '0;
    win = '0;
    hit = '0;
    req_o = '0;
    wen_o = '0;
    wdata_o = '0;
    hs = '0;
    push = '0;
    gnt_o = '0;
    inc = '0;
    vld_o = '0;
    rdata_o = '0;
    for (int k = 0; k < NumOut; k++) begin
      for (int j = 0; j < NumIn; j++)
        elig[k][j] = req_i[j] && add_i[j] == OW'(k) && cnt[j] < CW'(MaxOutPerMaster) &&
                     (cnt[j] == '0 || last[j] == OW'(k));
      win[k] = rr_pick(elig[k], ExtPrio ? rr_i[k] : ptr[k]);
      req_o[k] = |elig[k] && !full[k];
      wen_o[k] = wen_i[win[k]];
      wdata_o[k] = wdata_i[win[k]];
      hs[k] = req_o[k] && gnt_i[k];
      push[k] = hs[k] && (WriteRespOn || !wen_o[k]);
      for (int j = 0; j < NumIn; j++) begin
        gnt_o[j] |= hs[k] && win[k] == IW'(j);
        inc[j] |= push[k] && win[k] == IW'(j);
        hit[j][k] = rvld_i[k] && !empty[k] && head[k] == IW'(j);
        rdata_o[j] |= hit[j][k] ? rdata_i[k] : '0;
      end
    end
    for (int j = 0; j < NumIn; j++) vld_o[j] = |hit[j];
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt <= '0;
      last <= '0;
      ptr <= '0;
    end else begin
      for (int k = 0; k < NumOut; k++)
        if (hs[k]) begin
          ptr[k] <= win[k] == IW'(NumIn - 1) ? '0 : win[k] + IW'(1);
          last[win[k]] <= OW'(k);
        end
      for (int j = 0; j < NumIn; j++) cnt[j] <= cnt[j] + CW'(inc[j]) - CW'(vld_o[j]);
    end
  end
  for (genvar k = 0; k < NumOut; k++) begin : g_fifo
    xbar_vlat_idx_fifo #(
      .Depth(MaxOutstanding),
      .Width(IW)
    ) u_fifo (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .push_i (push[k]),
      .pop_i  (rvld_i[k]),
      .data_i (win[k]),
      .full_o (full[k]),
      .empty_o(empty[k]),
      .head_o (head[k])
    );
  end
  for (genvar j = 0; j < NumIn; j++) begin : g_vld
    assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(hit[j]));
  end
  if (NumIn < 1 || NumOut < 1) begin : g_bad_param
    $error("xbar_vlat needs NumIn >= 1 and NumOut >= 1");
  end
endmodule
